// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial bit-pattern detector with FILL/RUN FSM and match pulse
// Optional saturating match counter is built only when SEQ_DET_CNT_EN is defined.
module seq_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_LEN-1:0]  win_q, win_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                match_q, match_d;
    logic                armed_q, armed_d;

    logic                accept;
    logic                full_next;
    logic                hit;
    logic [PAT_LEN-1:0]  win_shift;

    // armed_q stays low for the first edge after reset release so a bit
    // presented on an edge racing the deassertion is never consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        armed_d   = 1'b1;
        accept    = en && armed_q;
        win_shift = {win_q[PAT_LEN-2:0], din};
        full_next = (state_q == S_RUN) || (fill_q == FILL_W'(PAT_LEN - 1));
        hit       = accept && full_next && (win_shift == PATTERN);

        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        if (clr) begin
            state_d = S_FILL;
            win_d   = '0;
            fill_d  = '0;
        end else if (accept) begin
            win_d   = win_shift;
            match_d = hit;
            case (state_q)
                S_FILL: begin
                    if (fill_q == FILL_W'(PAT_LEN - 1)) begin
                        state_d = S_RUN;
                        fill_d  = FILL_W'(PAT_LEN);
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_FILL;
                    fill_d  = '0;
                end
            endcase
            // Non-overlapping mode: the next match must be built from fresh bits.
            if (hit && !OVERLAP) begin
                state_d = S_FILL;
                fill_d  = '0;
            end
        end
    end

    assign match = match_q;
    assign busy  = (state_q == S_RUN);

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: target pattern, PAT_LEN bits wide, MSB is the oldest bit.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  din is valid and consumed this cycle.
REQ-008 din  input  1  serial data bit.
REQ-009 clr  input  1  synchronous clear of history, fill state and counter.
REQ-010 match  output  1  registered one-cycle pulse, pattern just completed.
REQ-011 match_cnt  output  CNT_W  number of matches since reset or clr.
REQ-012 busy  output  1  high while in RUN state (window fully populated).

Function
REQ-013 The block SHALL keep a PAT_LEN-bit shift window; each accepted bit (en=1) SHALL shift in at the LSB.
REQ-014 The FSM SHALL have two states: FILL (fewer than PAT_LEN valid bits in the window) and RUN (window full).
REQ-015 A fill counter SHALL count accepted bits in FILL; FILL->RUN SHALL occur when the PAT_LEN-th bit is accepted.
REQ-016 A match SHALL be detected when the window, including the bit accepted this cycle, equals PATTERN and PAT_LEN valid bits are present.
REQ-017 match SHALL assert exactly one cycle after the edge at which the completing bit is accepted (latency 1), for one cycle only.
REQ-018 With OVERLAP=1, the state SHALL remain RUN after a match, so the next match can reuse trailing bits.
REQ-019 With OVERLAP=0, a match SHALL force the state to FILL with the fill count at 0, so the next match needs PAT_LEN fresh bits.
REQ-020 With en=0, the window, the state and the counter SHALL hold, and match SHALL be 0 in the following cycle.
REQ-021 match_cnt SHALL increment by 1 per match and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-022 clr=1 SHALL zero the window, fill count and match_cnt, force FILL, and force match to 0 next cycle.
REQ-023 If clr and en are high in the same cycle, clr SHALL win and the din bit SHALL be discarded.
REQ-024 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, set state=FILL, window=0, fill count=0, match=0, match_cnt=0, busy=0.
REQ-026 Reset asserted mid-pattern SHALL discard all partial history; after release, detection SHALL restart from FILL.
REQ-027 No bit SHALL be accepted on the first rising edge coincident with rst_n deassertion.

Configuration
REQ-028 Macro SEQ_DET_CNT_EN defined: the match_cnt counter and its saturation logic SHALL be present as specified.
REQ-029 Macro SEQ_DET_CNT_EN undefined: no counter register SHALL be built, match_cnt SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Check overlap: PATTERN=1011, OVERLAP=1, en=1, stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt=2.
REQ-031 Check non-overlap: same stream with OVERLAP=0 -> single match after bit 4; match_cnt=1; busy=0 the cycle after that match.
REQ-032 Check en gaps: stream 1,0,1,1 with en=0 for 3 cycles between bit 2 and bit 3 -> one match, one cycle after bit 4 is accepted; no pulses during the gaps.
REQ-033 Check saturation: CNT_W=2, OVERLAP=1, stream 1011011011011 (4 matches) -> match_cnt reads 3 after the 3rd match and stays 3.
REQ-034 Check clr: clr asserted together with en on bit 4 of 1011 -> no match, match_cnt=0, state FILL; then 1011 -> match after its 4th bit.
REQ-035 Check async reset: rst_n pulsed low between clock edges after bits 1,0,1 -> outputs clear at once; subsequent 1 then 011 -> match only after the 4th post-reset bit.
